// File: rtl/qn_coinc_pkg.sv
// Shared FSM encoding and event-word layout for the tube coincidence builder.
// Event word: {START_TIME, HIT_MASK, TUBE_TIME[N_TUBES-1] .. TUBE_TIME[0]}.
package qn_coinc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OPEN  = 2'd1,
    ST_CLOSE = 2'd2,
    ST_DEAD  = 2'd3
  } coinc_state_e;

  function automatic int unsigned event_w(input int unsigned time_w, input int unsigned n_tubes);
    return time_w + n_tubes + n_tubes * time_w;
  endfunction

  function automatic int unsigned tube_time_lsb(input int unsigned time_w, input int unsigned tube);
    return tube * time_w;
  endfunction

  function automatic int unsigned hit_mask_lsb(input int unsigned time_w, input int unsigned n_tubes);
    return n_tubes * time_w;
  endfunction

  function automatic int unsigned start_time_lsb(input int unsigned time_w, input int unsigned n_tubes);
    return n_tubes * time_w + n_tubes;
  endfunction

endpackage

// File: rtl/qn_event_fifo.sv
// First-word-fall-through event FIFO with registered full/empty flags.
// A push while full is dropped, even when a pop happens in the same cycle.
module qn_event_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned SLOTS = 1 << AW;

  logic [WIDTH-1:0] mem [SLOTS];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign count_nxt = count + CW'(push_ok) - CW'(pop_ok);
  assign rdata     = mem[rd_ptr];

  // Storage is not cleared by reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/tube_coincidence_builder.sv
// Timestamps synchronized tube hits, groups them into coincidence windows and queues events.
// Optional dead time after each window close is enabled by defining QN_DEADTIME_EN.
module tube_coincidence_builder
  import qn_coinc_pkg::*;
#(
  parameter int unsigned N_TUBES     = 4,
  parameter int unsigned TIME_W      = 8,
  parameter int unsigned WINDOW      = 16,
  parameter int unsigned MIN_HITS    = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned DEAD_CYCLES = 8
) (
  input  logic                                     CLK,
  input  logic                                     RESET,
  input  logic [N_TUBES-1:0]                       TUBE_SIGNAL,
  input  logic                                     EVENT_READY,
  output logic                                     EVENT_VALID,
  output logic [event_w(TIME_W, N_TUBES)-1:0]      EVENT_DATA,
  output logic                                     BUSY,
  output logic [7:0]                               DROP_COUNT
);

  localparam int unsigned EVT_W = event_w(TIME_W, N_TUBES);
  localparam int unsigned CNT_W = $clog2(N_TUBES + 1);
`ifdef QN_DEADTIME_EN
  localparam bit DEAD_EN = 1'b1;
`else
  localparam bit DEAD_EN = 1'b0;
`endif
  localparam int unsigned DEAD_LEN = DEAD_EN ? DEAD_CYCLES : 0;
  localparam int unsigned DEAD_W   = $clog2(DEAD_LEN + 2);

  logic [N_TUBES-1:0] sync0, sync1, sync2, hit;
  logic [TIME_W-1:0]  timer;
  logic [TIME_W-1:0]  start_time;
  logic [N_TUBES-1:0] mask;
  logic [TIME_W-1:0]  tube_time [N_TUBES];
  logic [TIME_W-1:0]  win_idx;
  logic [DEAD_W-1:0]  dead_cnt;
  coinc_state_e       state;
  logic [CNT_W-1:0]   hit_cnt;
  logic               qualify;
  logic               push;
  logic               fifo_full;
  logic               fifo_empty;
  logic [EVT_W-1:0]   evt_data;
  logic [EVT_W-1:0]   fifo_rdata;

  // Two-flop synchronizer, registered rising-edge detect and free-running timestamp.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync0 <= '0;
      sync1 <= '0;
      sync2 <= '0;
      hit   <= '0;
      timer <= '0;
    end else begin
      sync0 <= TUBE_SIGNAL;
      sync1 <= sync0;
      sync2 <= sync1;
      hit   <= sync1 & ~sync2;
      timer <= timer + TIME_W'(1);
    end
  end

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < int'(N_TUBES); i++) hit_cnt = hit_cnt + CNT_W'(mask[i]);
  end

  assign qualify = (hit_cnt >= CNT_W'(MIN_HITS));
  assign push    = (state == ST_CLOSE) && qualify;

  always_comb begin
    evt_data = '0;
    evt_data[start_time_lsb(TIME_W, N_TUBES) +: TIME_W] = start_time;
    evt_data[hit_mask_lsb(TIME_W, N_TUBES) +: N_TUBES]  = mask;
    for (int i = 0; i < int'(N_TUBES); i++)
      evt_data[tube_time_lsb(TIME_W, i) +: TIME_W] = tube_time[i];
  end

  // Window FSM: first hit opens, first hit per tube wins, CLOSE decides keep/drop.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      BUSY       <= 1'b0;
      mask       <= '0;
      start_time <= '0;
      win_idx    <= '0;
      dead_cnt   <= '0;
      DROP_COUNT <= '0;
      for (int i = 0; i < int'(N_TUBES); i++) tube_time[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|hit) begin
            start_time <= timer;
            mask       <= hit;
            win_idx    <= TIME_W'(1);
            for (int i = 0; i < int'(N_TUBES); i++)
              if (hit[i]) tube_time[i] <= timer;
            state <= (WINDOW == 1) ? ST_CLOSE : ST_OPEN;
            BUSY  <= 1'b1;
          end
        end
        ST_OPEN: begin
          for (int i = 0; i < int'(N_TUBES); i++) begin
            if (hit[i] && !mask[i]) begin
              mask[i]      <= 1'b1;
              tube_time[i] <= timer;
            end
          end
          if (win_idx == TIME_W'(WINDOW - 1)) state <= ST_CLOSE;
          win_idx <= win_idx + TIME_W'(1);
        end
        ST_CLOSE: begin
          if (qualify && fifo_full && (DROP_COUNT != 8'hFF)) DROP_COUNT <= DROP_COUNT + 8'd1;
          mask       <= '0;
          start_time <= '0;
          for (int i = 0; i < int'(N_TUBES); i++) tube_time[i] <= '0;
          if (DEAD_LEN != 0) begin
            state    <= ST_DEAD;
            dead_cnt <= DEAD_W'(1);
          end else begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
          end
        end
        ST_DEAD: begin
          if (dead_cnt == DEAD_W'(DEAD_LEN)) begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
          end
          dead_cnt <= dead_cnt + DEAD_W'(1);
        end
        default: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

  qn_event_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (push),
    .wdata (evt_data),
    .pop   (EVENT_READY),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign EVENT_VALID = !fifo_empty;
  assign EVENT_DATA  = fifo_empty ? '0 : fifo_rdata;

endmodule
